spi_shift_ctrl: RTL and testbench
=================================

SPI_SHIFT_CTRL -- requirements
Module: spi_shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving bits per transfer (legal range 2..32).
REQ-002 SHALL have parameter DIV, default 2, giving the sclk half-period in clk cycles (legal minimum 1).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tx_valid  input  1  transfer request.
REQ-006 SHALL have port tx_ready  output  1  request accepted when tx_valid and tx_ready are both high.
REQ-007 SHALL have port tx_data  input  WIDTH  word to transmit.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse indicating that rx_data is valid.
REQ-009 SHALL have port rx_data  output  WIDTH  received word, held until the next rx_valid.
REQ-010 SHALL have port sclk  output  1  serial clock, idle low (mode 0).
REQ-011 SHALL have port mosi  output  1  serial data out.
REQ-012 SHALL have port miso  input  1  serial data in.
REQ-013 SHALL have port cs_n  output  1  chip select, active-low.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, SETUP, SHIFT and DONE.
REQ-016 In IDLE, tx_ready SHALL be 1; in every other state it SHALL be 0, and tx_valid SHALL be ignored.
REQ-017 On acceptance in cycle A, the block SHALL capture tx_data into the shift buffer and enter SETUP at A+1.
REQ-018 In SETUP, the block SHALL hold cs_n=0 and sclk=0, drive mosi with the first bit, and remain for DIV cycles.
REQ-019 SHIFT SHALL run 2*WIDTH half-periods of DIV cycles each, with sclk=1 during the odd half-periods.
REQ-020 On each clk edge where sclk rises, the block SHALL sample miso into the receive buffer.
REQ-021 On each clk edge where sclk falls (except the last), the block SHALL shift mosi to the next bit.
REQ-022 A bit counter SHALL count rising edges, and SHIFT SHALL exit after the WIDTH-th falling edge.
REQ-023 The block SHALL enter DONE at A+1+DIV*(2*WIDTH+1), with cs_n=1, rx_valid=1 and rx_data updated in that cycle.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE, so that the minimum gap between transfers is 1 IDLE cycle.
REQ-025 mosi SHALL be 0 in IDLE and DONE.
REQ-026 The half-period counter SHALL be ceil(log2(DIV+1)) bits wide, and the bit counter ceil(log2(WIDTH+1)) bits.

Reset
REQ-027 Reset SHALL set tx_ready=1, rx_valid=0, rx_data=0, sclk=0, mosi=0, cs_n=1, busy=0, all counters to 0, and the state to IDLE.
REQ-028 Reset asserted mid-transfer SHALL deassert cs_n immediately (asynchronously), produce no rx_valid, and discard the partial word.

Configuration
REQ-029 Macro SPI_SHIFT_LSB_FIRST_EN SHALL control bit order.
REQ-030 When SPI_SHIFT_LSB_FIRST_EN is defined, both tx and rx SHALL be LSB-first, with tx_data[0] sent first and the first sampled bit placed in rx_data[0].
REQ-031 When SPI_SHIFT_LSB_FIRST_EN is undefined, both directions SHALL be MSB-first.

Structure
REQ-032 Package spi_shift_pkg SHALL hold the state enum type and the state encodings.
REQ-033 Sub-module spi_shifter SHALL hold the combined load/shift-out/shift-in register (parallel load, serial out, serial in, parallel out), sequenced by spi_shift_ctrl via load, shift_out and sample strobes.

Verification
REQ-034 Basic transfer: with WIDTH=8, DIV=2, send 0xA5 with miso looped to mosi -> rx_valid pulses at A+35, rx_data=0xA5, mosi sequence 1,0,1,0,0,1,0,1, 8 sclk pulses each 2 cycles high.
REQ-035 Receive only: send tx_data 0x00 with miso driven 0x3C from a slave model -> rx_data=0x3C, cs_n low from A+1 to A+34 inclusive.
REQ-036 Busy rejection: hold tx_valid with 0x11 during a transfer of 0xF0 -> 0x11 is accepted only at A+36, and exactly 2 rx_valid pulses occur.
REQ-037 Reset mid-transfer: drop rstn at A+10 -> cs_n=1 and sclk=0 in the same cycle, no rx_valid, and a subsequent 0x5A transfer completes correctly.
REQ-038 Edge parameters: with DIV=1, WIDTH=2, send 0b10 with loopback -> rx_valid at A+6, rx_data=0b10.
REQ-039 Bit order: with SPI_SHIFT_LSB_FIRST_EN defined, send 0x01 -> mosi is 1 in the first bit slot only, and loopback gives rx_data=0x01.

Source files
------------

// File: rtl/spi_shift_pkg.sv
// Shared types for the SPI shift controller: FSM state encoding.
package spi_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/spi_shift_if.sv
// Bus bundle between the SPI shift controller (master modport) and its user/peripheral (slave modport).
interface spi_shift_if
    import spi_shift_pkg::*;
#(
    parameter int WIDTH = 8
);
    // Handshake: a word is taken on a rising clk edge where tx_valid and tx_ready are both 1;
    // tx_data must be stable while tx_valid is high. rx_valid is a one-cycle pulse with no ready.
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             cs_n;
    logic             busy;
    state_t           dbg_state;

    modport master (
        input  tx_valid, tx_data, miso,
        output tx_ready, rx_valid, rx_data, sclk, mosi, cs_n, busy, dbg_state
    );

    modport slave (
        output tx_valid, tx_data, miso,
        input  tx_ready, rx_valid, rx_data, sclk, mosi, cs_n, busy, dbg_state
    );

endinterface

// File: rtl/spi_shifter.sv
// Transmit/receive shift register pair: parallel load, serial out, serial in, parallel out.
// Bit order is LSB-first when SPI_SHIFT_LSB_FIRST_EN is defined, otherwise MSB-first.
module spi_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_out,
    input  logic             sample,
    input  logic             miso,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_q <= '0;
            rx_q <= '0;
        end else if (load) begin
            tx_q <= load_data;
            rx_q <= '0;
        end else begin
`ifdef SPI_SHIFT_LSB_FIRST_EN
            if (shift_out) tx_q <= {1'b0, tx_q[WIDTH-1:1]};
            if (sample)    rx_q <= {miso, rx_q[WIDTH-1:1]};
`else
            if (shift_out) tx_q <= {tx_q[WIDTH-2:0], 1'b0};
            if (sample)    rx_q <= {rx_q[WIDTH-2:0], miso};
`endif
        end
    end

`ifdef SPI_SHIFT_LSB_FIRST_EN
    assign ser_out = tx_q[0];
`else
    assign ser_out = tx_q[WIDTH-1];
`endif
    assign par_out = rx_q;

endmodule

// File: rtl/spi_shift_ctrl.sv
// Mode-0 SPI master: one word per transfer, sclk half-period of DIV clk cycles.
// Bit order selected by SPI_SHIFT_LSB_FIRST_EN (see spi_shifter).
module spi_shift_ctrl
    import spi_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    spi_shift_if.master bus
);

    localparam int DIV_W = $clog2(DIV + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_COUNT = BIT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic [WIDTH-1:0] rx_data_q;
    logic             load, shift_out, sample, rx_update;
    logic             half_end;
    logic             ser_out;
    logic [WIDTH-1:0] par_out;

    assign half_end = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            if (rx_update) rx_data_q <= par_out;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        load      = 1'b0;
        shift_out = 1'b0;
        sample    = 1'b0;
        rx_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.tx_valid) begin
                    load    = 1'b1;
                    state_d = ST_SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (half_end) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!half_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    // Low half ends: sclk rises, miso is captured.
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sample = 1'b1;
                        bit_d  = bit_q + BIT_W'(1);
                    end else if (bit_q == BIT_COUNT) begin
                        sclk_d    = 1'b0;
                        state_d   = ST_DONE;
                        rx_update = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        shift_out = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    spi_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .load_data (bus.tx_data),
        .shift_out (shift_out),
        .sample    (sample),
        .miso      (bus.miso),
        .ser_out   (ser_out),
        .par_out   (par_out)
    );

    // cs_n and mosi decode straight from state so reset releases the bus at once.
    assign bus.tx_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.cs_n      = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
    assign bus.mosi      = ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) ? ser_out : 1'b0;
    assign bus.sclk      = sclk_q;
    assign bus.rx_valid  = (state_q == ST_DONE);
    assign bus.rx_data   = rx_data_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Self-checking bench for spi_shift_ctrl: 8-bit/DIV=2 instance plus a 2-bit/DIV=1 edge instance.
module tb_spi_shift_ctrl;
  import spi_shift_pkg::*;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int W2 = 2;
  localparam int D2 = 1;
  localparam int LAT_A = 1 + D * (2 * W + 1);
  localparam int LAT_B = 1 + D2 * (2 * W2 + 1);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_shift_if #(.WIDTH(W))  a_if ();
  spi_shift_if #(.WIDTH(W2)) b_if ();

  spi_shift_ctrl #(.WIDTH(W), .DIV(D)) dut_a (.clk(clk), .rstn(rstn), .bus(a_if));
  spi_shift_ctrl #(.WIDTH(W2), .DIV(D2)) dut_b (.clk(clk), .rstn(rstn), .bus(b_if));

  int n_cmp = 0;
  int n_fail = 0;

  // Peripheral model: loopback, or a slave that presents one bit per sclk period (mode 0).
  logic         loop_a = 1'b1;
  logic [W-1:0] slave_word = '0;
  int           fall_a = 0;
  logic         slave_bit;

  function automatic int bit_pos(input int i, input int width);
`ifdef SPI_SHIFT_LSB_FIRST_EN
    return i;
`else
    return width - 1 - i;
`endif
  endfunction

  always @(negedge a_if.cs_n) fall_a = 0;
  always @(negedge a_if.sclk) if (!a_if.cs_n) fall_a = fall_a + 1;

  always_comb begin
    slave_bit = 1'b0;
    if (fall_a < W) slave_bit = slave_word[bit_pos(fall_a, W)];
  end

  assign a_if.miso = loop_a ? a_if.mosi : slave_bit;
  assign b_if.miso = b_if.mosi;

  // Drives one word into dut_a and observes the whole transfer up to one cycle past rx_valid.
  task automatic run_xfer_a(input logic [W-1:0] word, input logic loop, input logic [W-1:0] sword,
                            output logic acc_ok, output int lat, output logic [W-1:0] rx,
                            output logic [W-1:0] mosi_word, output int pulses, output int bad_pulse,
                            output int cs_low, output logic done_ok);
    int k, nbit, hi_run;
    logic prev_sclk, got;
    loop_a = loop; slave_word = sword;
    lat = -1; rx = '0; mosi_word = '0; pulses = 0; bad_pulse = 0; cs_low = 0; done_ok = 1'b0;
    k = 0; nbit = 0; hi_run = 0; prev_sclk = 1'b0; got = 1'b0;
    @(negedge clk);
    acc_ok = a_if.tx_ready;
    a_if.tx_valid = 1'b1;
    a_if.tx_data  = word;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      a_if.tx_valid = 1'b0;
      if (!a_if.cs_n) cs_low++;
      if (a_if.sclk && !prev_sclk) begin
        if (nbit < W) mosi_word[bit_pos(nbit, W)] = a_if.mosi;
        nbit++;
      end
      if (a_if.sclk) hi_run++;
      else if (prev_sclk) begin
        pulses++;
        if (hi_run != D) bad_pulse++;
        hi_run = 0;
      end
      prev_sclk = a_if.sclk;
      if (a_if.rx_valid) begin
        got = 1'b1; lat = k; rx = a_if.rx_data;
        done_ok = (a_if.cs_n === 1'b1) && (a_if.mosi === 1'b0);
      end
    end
    if (got) begin
      @(negedge clk);
      done_ok = done_ok && (a_if.rx_valid === 1'b0) && (a_if.tx_ready === 1'b1) && (a_if.rx_data === rx);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (a_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", a_if.tx_ready); end
    n_cmp++; if (a_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", a_if.rx_valid); end
    n_cmp++; if (a_if.rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", a_if.rx_data); end
    n_cmp++; if ({a_if.sclk, a_if.mosi, a_if.cs_n, a_if.busy} !== 4'b0010) begin
      n_fail++; $display("FAIL reset_bus: got sclk/mosi/cs_n/busy=%b want 0010", {a_if.sclk, a_if.mosi, a_if.cs_n, a_if.busy});
    end
    n_cmp++; if (a_if.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", a_if.dbg_state, ST_IDLE); end
    n_cmp++; if ({b_if.tx_ready, b_if.cs_n, b_if.busy, b_if.rx_data} !== {3'b110, 2'b00}) begin
      n_fail++; $display("FAIL reset_b: got ready/cs_n/busy/rx=%b want 11000", {b_if.tx_ready, b_if.cs_n, b_if.busy, b_if.rx_data});
    end
  endtask

  task automatic test_basic();
    logic acc; int lat, pulses, badp, csl; logic [W-1:0] rx, mw; logic dn;
    run_xfer_a(8'hA5, 1'b1, 8'h00, acc, lat, rx, mw, pulses, badp, csl, dn);
    n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b want 1", acc); end
    n_cmp++; if (lat !== LAT_A) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT_A); end
    n_cmp++; if (rx !== 8'hA5) begin n_fail++; $display("FAIL basic_rx: got %h want a5", rx); end
    n_cmp++; if (mw !== 8'hA5) begin n_fail++; $display("FAIL basic_mosi: got %h want a5", mw); end
    n_cmp++; if (pulses !== W || badp !== 0) begin
      n_fail++; $display("FAIL basic_sclk: got %0d pulses (%0d bad width) want %0d of %0d cycles", pulses, badp, W, D);
    end
    n_cmp++; if (csl !== LAT_A - 1) begin n_fail++; $display("FAIL basic_cs_low: got %0d want %0d", csl, LAT_A - 1); end
    n_cmp++; if (dn !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", dn); end
  endtask

  task automatic test_receive_only();
    logic acc; int lat, pulses, badp, csl; logic [W-1:0] rx, mw; logic dn;
    run_xfer_a(8'h00, 1'b0, 8'h3C, acc, lat, rx, mw, pulses, badp, csl, dn);
    n_cmp++; if (rx !== 8'h3C) begin n_fail++; $display("FAIL rxonly_rx: got %h want 3c", rx); end
    n_cmp++; if (mw !== 8'h00) begin n_fail++; $display("FAIL rxonly_mosi: got %h want 00", mw); end
    n_cmp++; if (csl !== 2 * W * D + D) begin n_fail++; $display("FAIL rxonly_cs_low: got %0d want %0d", csl, 2 * W * D + D); end
    n_cmp++; if (lat !== LAT_A || dn !== 1'b1) begin n_fail++; $display("FAIL rxonly_done: got lat %0d done %b want %0d 1", lat, dn, LAT_A); end
  endtask

  task automatic test_random();
    logic acc; int lat, pulses, badp, csl; logic [W-1:0] rx, mw, word, sw, exp_rx; logic dn, lp;
    for (int t = 0; t < 12; t++) begin
      word = W'($urandom); sw = W'($urandom); lp = 1'($urandom_range(0, 1));
      exp_rx = lp ? word : sw;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_xfer_a(word, lp, sw, acc, lat, rx, mw, pulses, badp, csl, dn);
      n_cmp++; if (rx !== exp_rx) begin n_fail++; $display("FAIL rand_rx[%0d]: got %h want %h", t, rx, exp_rx); end
      n_cmp++; if (mw !== word) begin n_fail++; $display("FAIL rand_mosi[%0d]: got %h want %h", t, mw, word); end
      n_cmp++; if (lat !== LAT_A || !acc || !dn || pulses !== W) begin
        n_fail++; $display("FAIL rand_timing[%0d]: got lat %0d acc %b done %b pulses %0d want %0d 1 1 %0d", t, lat, acc, dn, pulses, LAT_A, W);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q[$];
    int k, acc2, nvalid;
    logic [W-1:0] exp_w;
    exp_q.push_back(8'hF0); exp_q.push_back(8'h11);
    loop_a = 1'b1; acc2 = -1; nvalid = 0;
    @(negedge clk);
    n_cmp++; if (a_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", a_if.tx_ready); end
    a_if.tx_valid = 1'b1; a_if.tx_data = 8'hF0;
    for (k = 1; k <= 2 * LAT_A + 10; k++) begin
      @(negedge clk);
      if (k == 1) a_if.tx_data = 8'h11;
      if (acc2 >= 0 && k == acc2 + 1) a_if.tx_valid = 1'b0;
      if (a_if.rx_valid) begin
        nvalid++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++; if (a_if.rx_data !== exp_w) begin n_fail++; $display("FAIL b2b_rx[%0d]: got %h want %h", nvalid, a_if.rx_data, exp_w); end
      end
      if (acc2 < 0 && a_if.tx_valid && a_if.tx_ready) acc2 = k;
    end
    a_if.tx_valid = 1'b0;
    n_cmp++; if (acc2 !== LAT_A + 1) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc2, LAT_A + 1); end
    n_cmp++; if (nvalid !== 2) begin n_fail++; $display("FAIL b2b_rx_count: got %0d want 2", nvalid); end
  endtask

  task automatic test_reset_mid();
    logic acc; int lat, pulses, badp, csl, nvalid; logic [W-1:0] rx, mw; logic dn;
    loop_a = 1'b1; nvalid = 0;
    @(negedge clk);
    a_if.tx_valid = 1'b1; a_if.tx_data = 8'h96;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      a_if.tx_valid = 1'b0;
    end
    n_cmp++; if (a_if.cs_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre_cs_n: got %b want 0", a_if.cs_n); end
    #1 rstn = 1'b0;
    #1;
    n_cmp++; if (a_if.cs_n !== 1'b1 || a_if.sclk !== 1'b0 || a_if.busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got cs_n/sclk/busy=%b want 100", {a_if.cs_n, a_if.sclk, a_if.busy});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (a_if.rx_valid) nvalid++;
    end
    n_cmp++; if (nvalid !== 0) begin n_fail++; $display("FAIL rstmid_no_rx_valid: got %0d want 0", nvalid); end
    n_cmp++; if (a_if.rx_data !== '0) begin n_fail++; $display("FAIL rstmid_discard: got %h want 00", a_if.rx_data); end
    run_xfer_a(8'h5A, 1'b1, 8'h00, acc, lat, rx, mw, pulses, badp, csl, dn);
    n_cmp++; if (rx !== 8'h5A || lat !== LAT_A || !dn) begin
      n_fail++; $display("FAIL rstmid_recover: got rx %h lat %0d done %b want 5a %0d 1", rx, lat, dn, LAT_A);
    end
  endtask

  task automatic test_edge_params();
    logic [W2-1:0] words[4];
    logic [W2-1:0] rx;
    int lat;
    words[0] = 2'b10; words[1] = 2'b01; words[2] = 2'b11; words[3] = 2'($urandom);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      b_if.tx_valid = 1'b1; b_if.tx_data = words[t];
      lat = -1; rx = '0;
      for (int k = 1; k <= 30 && lat < 0; k++) begin
        @(negedge clk);
        b_if.tx_valid = 1'b0;
        if (b_if.rx_valid) begin lat = k; rx = b_if.rx_data; end
      end
      n_cmp++; if (lat !== LAT_B) begin n_fail++; $display("FAIL edge_latency[%0d]: got %0d want %0d", t, lat, LAT_B); end
      n_cmp++; if (rx !== words[t]) begin n_fail++; $display("FAIL edge_rx[%0d]: got %b want %b", t, rx, words[t]); end
    end
  endtask

  initial begin
    a_if.tx_valid = 1'b0; a_if.tx_data = '0;
    b_if.tx_valid = 1'b0; b_if.tx_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_receive_only();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_edge_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
